// File: rtl/gb_cpu_mem_bridge.sv
// gb_cpu_mem_bridge: turns GameBoy CPU external memory cycles into single
// request/acknowledge transactions. It holds the CPU with cpu_wait_n until
// each transaction completes or times out.
// Optional feature macro: GB_MEMBRIDGE_WRPOST_EN. When defined, writes are
// posted, and one access arriving during a posted write is queued.
module gb_cpu_mem_bridge #(
  parameter logic [15:0] WIN0_LO = 16'h0000,
  parameter logic [15:0] WIN0_HI = 16'h7FFF,
  parameter logic [15:0] WIN1_LO = 16'hA000,
  parameter logic [15:0] WIN1_HI = 16'hBFFF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_mreq_n,
  input  logic        cpu_rd_n,
  input  logic        cpu_wr_n,
  output logic [7:0]  cpu_di,
  output logic        cpu_wait_n,
  output logic        ext_sel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        timeout_err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, WR_REQ, DONE, PEND} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_q, wr_q;
  logic             rd_act, wr_act, start_rd, start_wr, fin;
  logic [7:0]       cpu_di_d, mem_wdata_d;
  logic [15:0]      mem_addr_d;
  logic             mem_req_d, mem_we_d, timeout_err_d;

`ifdef GB_MEMBRIDGE_WRPOST_EN
  logic             hold_q, hold_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_we_q, pend_we_d;
  logic [15:0]      pend_addr_q, pend_addr_d;
  logic [7:0]       pend_wdata_q, pend_wdata_d;
  logic             pend_cap;
`endif

  // Address window decode; the offset compare avoids constant-bound comparisons
  assign ext_sel = (16'(cpu_a - WIN0_LO) <= 16'(WIN0_HI - WIN0_LO)) ||
                   (16'(cpu_a - WIN1_LO) <= 16'(WIN1_HI - WIN1_LO));

  assign rd_act   = !cpu_mreq_n && !cpu_rd_n;
  assign wr_act   = !cpu_mreq_n && !cpu_wr_n;
  assign start_wr = wr_act && !wr_q && ext_sel;
  assign start_rd = rd_act && !rd_q && ext_sel && !wr_act;
  assign fin      = mem_ack || (cnt_q == CNT_LAST);

`ifdef GB_MEMBRIDGE_WRPOST_EN
  // Queue one access that arrives while a posted write is draining
  assign pend_cap = (state_q == WR_REQ) && !hold_q && !pend_vld_q && (start_rd || start_wr);

  // Hold the CPU for reads, queued accesses and non-posted transactions
  assign cpu_wait_n = !(start_rd || (start_wr && (state_q != IDLE)) || pend_vld_q ||
                        (state_q == PEND) || (state_q == RD_REQ) ||
                        ((state_q == WR_REQ) && hold_q));
`else
  // Hold the CPU from the first strobe cycle until the transaction ends
  assign cpu_wait_n = !(start_rd || start_wr || (state_q == RD_REQ) || (state_q == WR_REQ));
`endif

  // Strobe history for edge detection
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      rd_q <= rd_act;
      wr_q <= wr_act;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cpu_di_d      = cpu_di;
    mem_req_d     = mem_req;
    mem_we_d      = mem_we;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;
    timeout_err_d = timeout_err;
`ifdef GB_MEMBRIDGE_WRPOST_EN
    hold_d        = hold_q;
    pend_vld_d    = pend_vld_q;
    pend_we_d     = pend_we_q;
    pend_addr_d   = pend_addr_q;
    pend_wdata_d  = pend_wdata_q;
    if (pend_cap) begin
      pend_vld_d   = 1'b1;
      pend_we_d    = start_wr;
      pend_addr_d  = cpu_a;
      pend_wdata_d = cpu_do;
    end
`endif
    case (state_q)
      IDLE: begin
        if (start_wr) begin
          mem_addr_d  = cpu_a;
          mem_wdata_d = cpu_do;
          mem_we_d    = 1'b1;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = WR_REQ;
`ifdef GB_MEMBRIDGE_WRPOST_EN
          hold_d      = 1'b0;
`endif
        end else if (start_rd) begin
          mem_addr_d  = cpu_a;
          mem_we_d    = 1'b0;
          mem_req_d   = 1'b1;
          cnt_d       = '0;
          state_d     = RD_REQ;
`ifdef GB_MEMBRIDGE_WRPOST_EN
          hold_d      = 1'b1;
`endif
        end
      end
      RD_REQ, WR_REQ: begin
        if (fin) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (mem_ack) begin
            if (state_q == RD_REQ) cpu_di_d = mem_rdata;
          end else begin
            if (state_q == RD_REQ) cpu_di_d = 8'hFF;
            timeout_err_d = 1'b1;
          end
`ifdef GB_MEMBRIDGE_WRPOST_EN
          if ((state_q == WR_REQ) && !hold_q)
            state_d = (pend_vld_q || pend_cap) ? PEND : IDLE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (!rd_act && !wr_act) state_d = IDLE;
      end
`ifdef GB_MEMBRIDGE_WRPOST_EN
      PEND: begin
        mem_addr_d = pend_addr_q;
        mem_we_d   = pend_we_q;
        if (pend_we_q) mem_wdata_d = pend_wdata_q;
        mem_req_d  = 1'b1;
        cnt_d      = '0;
        hold_d     = 1'b1;
        pend_vld_d = 1'b0;
        state_d    = pend_we_q ? WR_REQ : RD_REQ;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cpu_di       <= 8'hFF;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      timeout_err  <= 1'b0;
`ifdef GB_MEMBRIDGE_WRPOST_EN
      hold_q       <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cpu_di       <= cpu_di_d;
      mem_req      <= mem_req_d;
      mem_we       <= mem_we_d;
      mem_addr     <= mem_addr_d;
      mem_wdata    <= mem_wdata_d;
      timeout_err  <= timeout_err_d;
`ifdef GB_MEMBRIDGE_WRPOST_EN
      hold_q       <= hold_d;
      pend_vld_q   <= pend_vld_d;
      pend_we_q    <= pend_we_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
`endif
    end
  end

endmodule

// File: tb/tb_gb_cpu_mem_bridge.sv
// Directed testbench for gb_cpu_mem_bridge (default TIMEOUT=64).
module tb_gb_cpu_mem_bridge;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_do;
  logic        cpu_mreq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0]  cpu_di;
  logic        cpu_wait_n, ext_sel;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;
  int req_rises = 0;
  int base;
  int low_cnt;
  logic req_prev = 1'b0;

  gb_cpu_mem_bridge dut (
    .clk_sys(clk_sys), .reset(reset), .cpu_a(cpu_a), .cpu_do(cpu_do),
    .cpu_mreq_n(cpu_mreq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_di(cpu_di), .cpu_wait_n(cpu_wait_n), .ext_sel(ext_sel),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  // Count mem_req rising edges, sampled mid-cycle
  always @(negedge clk_sys) begin
    if (mem_req && !req_prev) req_rises++;
    req_prev = mem_req;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic bus_idle();
    cpu_mreq_n = 1'b1;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b1;
  endtask

  task automatic bus_rd(input logic [15:0] a);
    cpu_a      = a;
    cpu_mreq_n = 1'b0;
    cpu_rd_n   = 1'b0;
    cpu_wr_n   = 1'b1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_a      = a;
    cpu_do     = d;
    cpu_mreq_n = 1'b0;
    cpu_rd_n   = 1'b1;
    cpu_wr_n   = 1'b0;
  endtask

  logic [15:0] ba [6];
  logic        be [6];
  logic        wr_wait_exp;

  initial begin
    ba = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hBFFF, 16'hC000};
    be = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef GB_MEMBRIDGE_WRPOST_EN
    wr_wait_exp = 1'b1;
`else
    wr_wait_exp = 1'b0;
`endif
    reset = 1'b1;
    bus_idle();
    cpu_a = 16'h0000;
    cpu_do = 8'h00;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    repeat (3) cyc();
    reset = 1'b0;

    // Reset state holds with no strobes
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      check("rst_cpu_di", 32'(cpu_di), 32'h FF);
      check("rst_wait_n", 32'(cpu_wait_n), 32'h1);
      check("rst_mem_req", 32'(mem_req), 32'h0);
      check("rst_terr", 32'(timeout_err), 32'h0);
    end
    check("rst_mem_addr", 32'(mem_addr), 32'h0);

    // Read 0x0150, ack 3 cycles after mem_req rises
    cyc(); bus_rd(16'h0150); #1;
    check("rd_wait_strobe", 32'(cpu_wait_n), 32'h0);
    check("rd_ext_sel", 32'(ext_sel), 32'h1);
    cyc(); #1;
    check("rd_req", 32'(mem_req), 32'h1);
    check("rd_addr", 32'(mem_addr), 32'h0150);
    check("rd_we", 32'(mem_we), 32'h0);
    check("rd_wait_req", 32'(cpu_wait_n), 32'h0);
    cyc(); cyc();
    mem_ack = 1'b1; mem_rdata = 8'h3E; #1;
    check("rd_wait_ack", 32'(cpu_wait_n), 32'h0);
    cyc(); mem_ack = 1'b0; #1;
    check("rd_data", 32'(cpu_di), 32'h3E);
    check("rd_wait_rel", 32'(cpu_wait_n), 32'h1);
    check("rd_req_drop", 32'(mem_req), 32'h0);
    cyc(); bus_idle(); #1;
    check("rd_one_req", 32'(req_rises), 32'd1);

    // Write 0xA123 = 5A, ack 1 cycle after mem_req rises
    cyc(); bus_wr(16'hA123, 8'h5A); #1;
    check("wr_wait_strobe", 32'(cpu_wait_n), 32'(wr_wait_exp));
    cyc(); mem_ack = 1'b1; #1;
    check("wr_req", 32'(mem_req), 32'h1);
    check("wr_we", 32'(mem_we), 32'h1);
    check("wr_wdata", 32'(mem_wdata), 32'h5A);
    check("wr_addr", 32'(mem_addr), 32'hA123);
    check("wr_wait_req", 32'(cpu_wait_n), 32'(wr_wait_exp));
    cyc(); mem_ack = 1'b0; #1;
    check("wr_req_drop", 32'(mem_req), 32'h0);
    check("wr_wait_rel", 32'(cpu_wait_n), 32'h1);
    check("wr_cpu_di_kept", 32'(cpu_di), 32'h3E);
    cyc(); bus_idle(); #1;

    // Window boundaries
    for (int i = 0; i < 6; i++) begin
      cpu_a = ba[i]; #1;
      check($sformatf("ext_sel_%h", ba[i]), 32'(ext_sel), 32'(be[i]));
    end

    // Read outside both windows
    cyc(); bus_rd(16'hC000); #1;
    check("nw_ext_sel", 32'(ext_sel), 32'h0);
    check("nw_wait", 32'(cpu_wait_n), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check("nw_req", 32'(mem_req), 32'h0);
      check("nw_wait_hold", 32'(cpu_wait_n), 32'h1);
    end
    check("nw_cpu_di", 32'(cpu_di), 32'h3E);
    check("nw_rises", 32'(req_rises), 32'd2);
    cyc(); bus_idle();

    // Ack coincident with timeout terminal count: ack wins
    cyc(); bus_rd(16'h1000);
    for (int i = 1; i <= 64; i++) begin
      cyc();
      if (i == 64) begin mem_ack = 1'b1; mem_rdata = 8'h99; end
    end
    #1;
    check("tc_wait_last", 32'(cpu_wait_n), 32'h0);
    cyc(); mem_ack = 1'b0; #1;
    check("tc_cpu_di", 32'(cpu_di), 32'h99);
    check("tc_terr", 32'(timeout_err), 32'h0);
    check("tc_wait", 32'(cpu_wait_n), 32'h1);
    cyc(); bus_idle();

    // Timeout on read of 0x4000 with ack withheld
    cyc(); bus_rd(16'h4000);
    low_cnt = 0;
    for (int i = 1; i <= 64; i++) begin
      cyc(); #1;
      if (!cpu_wait_n) low_cnt++;
    end
    check("to_low_cycles", 32'(low_cnt), 32'd64);
    check("to_req_last", 32'(mem_req), 32'h1);
    cyc(); #1;
    check("to_wait_rel", 32'(cpu_wait_n), 32'h1);
    check("to_cpu_di", 32'(cpu_di), 32'hFF);
    check("to_terr", 32'(timeout_err), 32'h1);
    check("to_req_drop", 32'(mem_req), 32'h0);
    mem_ack = 1'b1; mem_rdata = 8'h77;
    cyc(); mem_ack = 1'b0; bus_idle(); #1;
    check("late_ack_done", 32'(cpu_di), 32'hFF);
    cyc(); mem_ack = 1'b1;
    cyc(); mem_ack = 1'b0; #1;
    check("late_ack_idle", 32'(cpu_di), 32'hFF);
    check("late_ack_req", 32'(mem_req), 32'h0);
    check("terr_sticky", 32'(timeout_err), 32'h1);

    // Strobe held after ack does not retrigger; earliest release
    cyc(); bus_rd(16'h0200);
    cyc(); mem_ack = 1'b1; mem_rdata = 8'hA5;
    cyc(); mem_ack = 1'b0; #1;
    check("fast_wait_rel", 32'(cpu_wait_n), 32'h1);
    check("fast_cpu_di", 32'(cpu_di), 32'hA5);
    base = req_rises;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      check("hold_req", 32'(mem_req), 32'h0);
      check("hold_wait", 32'(cpu_wait_n), 32'h1);
    end
    check("hold_rises", 32'(req_rises), 32'(base));
    cyc(); bus_idle();
    cyc(); bus_rd(16'h0300);
    cyc(); mem_ack = 1'b1; mem_rdata = 8'h5C;
    cyc(); mem_ack = 1'b0; #1;
    check("reissue_cpu_di", 32'(cpu_di), 32'h5C);
    check("reissue_rises", 32'(req_rises), 32'(base + 1));
    cyc(); bus_idle();

`ifdef GB_MEMBRIDGE_WRPOST_EN
    // Posted write with a read queued behind it
    cyc(); bus_wr(16'hA010, 8'h11); #1;
    check("pw_wait_start", 32'(cpu_wait_n), 32'h1);
    cyc(); bus_rd(16'h0100); #1;
    check("pw_wait_cap", 32'(cpu_wait_n), 32'h0);
    check("pw_addr_held", 32'(mem_addr), 32'hA010);
    cyc(); mem_ack = 1'b1; #1;
    check("pw_wait_pend", 32'(cpu_wait_n), 32'h0);
    cyc(); mem_ack = 1'b0; #1;
    check("pw_gap_req", 32'(mem_req), 32'h0);
    check("pw_gap_wait", 32'(cpu_wait_n), 32'h0);
    cyc(); mem_ack = 1'b1; mem_rdata = 8'h42; #1;
    check("pw_rd_req", 32'(mem_req), 32'h1);
    check("pw_rd_addr", 32'(mem_addr), 32'h0100);
    check("pw_rd_we", 32'(mem_we), 32'h0);
    cyc(); mem_ack = 1'b0; #1;
    check("pw_rd_data", 32'(cpu_di), 32'h42);
    check("pw_rd_wait", 32'(cpu_wait_n), 32'h1);
    cyc(); bus_idle();
`endif

    // Reset during an outstanding transaction
    cyc(); bus_rd(16'h0400);
    cyc(); #1;
    check("mr_req", 32'(mem_req), 32'h1);
    reset = 1'b1; bus_idle();
    cyc(); #1;
    check("mr_req_drop", 32'(mem_req), 32'h0);
    check("mr_terr_clr", 32'(timeout_err), 32'h0);
    check("mr_cpu_di", 32'(cpu_di), 32'hFF);
    check("mr_wait", 32'(cpu_wait_n), 32'h1);
    reset = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
